// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU with zero and signed-overflow flags
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       ctrl,
    output logic             zero,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam int MSB = WIDTH - 1;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] next_result;
    logic             next_overflow;
    // Combinational datapath; SLT uses a true signed compare so it is immune to subtraction overflow
    always_comb begin
        sum = data1 + data2;
        diff = data1 - data2;
        lt = $signed(data1) < $signed(data2);
        ovf_add = (data1[MSB] == data2[MSB]) && (sum[MSB] != data1[MSB]);
        ovf_sub = (data1[MSB] != data2[MSB]) && (diff[MSB] != data1[MSB]);
        next_result = (ctrl == OP_AND) ? (data1 & data2) :
                      (ctrl == OP_OR)  ? (data1 | data2) :
                      (ctrl == OP_ADD) ? sum :
                      (ctrl == OP_SUB) ? diff :
                      (ctrl == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} :
                      (ctrl == OP_XOR) ? (data1 ^ data2) : '0;
        next_overflow = (ctrl == OP_ADD) ? ovf_add :
                        (ctrl == OP_SUB) ? ovf_sub : 1'b0;
    end
    // Register result and flags together so zero never lags result
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero <= 1'b1;
            overflow <= 1'b0;
        end else begin
            result <= next_result;
            zero <= (next_result == '0);
            overflow <= next_overflow;
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed literal checks plus randomized checks against a behavioural model
module tb_alu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic [3:0]  ctrl = 4'b0000;
    logic        zero;
    logic [31:0] result;
    logic        overflow;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_ok = 1'b0;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ovf;

    alu_core #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .data1(data1), .data2(data2), .ctrl(ctrl),
        .zero(zero), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference semantics in plain signed 64-bit arithmetic
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s = 0;
        r = '0;
        o = 1'b0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = a ^ b;
            default: r = '0;
        endcase
    endfunction

    // Model tracks what the DUT must hold after each edge
    always @(posedge clk) begin
        logic [31:0] r;
        logic        o;
        model(ctrl, data1, data2, r, o);
        if (reset) begin
            exp_result = '0;
            exp_zero = 1'b1;
            exp_ovf = 1'b0;
            model_ok = 1'b1;
        end else begin
            exp_result = r;
            exp_zero = (r == 0);
            exp_ovf = o;
        end
    end

    // Every-cycle comparison of DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            n_cmp++;
            if (result !== exp_result || zero !== exp_zero || overflow !== exp_ovf) begin
                n_bad++;
                $display("FAIL model t=%0t: got result=%h zero=%b ovf=%b, required result=%h zero=%b ovf=%b",
                         $time, result, zero, overflow, exp_result, exp_zero, exp_ovf);
            end
        end
    end

    task automatic apply(input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset = r;
        ctrl = c;
        data1 = a;
        data2 = b;
    endtask

    task automatic go_check(input string name, input logic r, input logic [3:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ez, input logic eo);
        apply(r, c, a, b);
        @(posedge clk);
        #1;
        n_cmp++;
        if (result !== er || zero !== ez || overflow !== eo) begin
            n_bad++;
            $display("FAIL %s: got result=%h zero=%b ovf=%b, required result=%h zero=%b ovf=%b",
                     name, result, zero, overflow, er, ez, eo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] unused [10] = '{4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
                                    4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
        logic [3:0] valid [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        go_check("reset", 1, 4'b0010, 32'd5, 32'd6, 32'd0, 1, 0);
        go_check("and", 0, 4'b0000, 32'd14, 32'd9, 32'd8, 0, 0);
        go_check("or", 0, 4'b0001, 32'd14, 32'd9, 32'd15, 0, 0);
        go_check("add", 0, 4'b0010, 32'd14, 32'd9, 32'd23, 0, 0);
        go_check("sub", 0, 4'b0110, 32'd14, 32'd9, 32'd5, 0, 0);
        go_check("slt_false", 0, 4'b0111, 32'd14, 32'd9, 32'd0, 1, 0);
        go_check("xor", 0, 4'b1100, 32'd14, 32'd9, 32'd7, 0, 0);
        go_check("nop", 0, 4'b1111, 32'd14, 32'd9, 32'd0, 1, 0);
        go_check("slt_pos", 0, 4'b0111, 32'd9, 32'd14, 32'd1, 0, 0);
        go_check("slt_neg1", 0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
        go_check("slt_min_max", 0, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 0, 0);
        go_check("sub_equal", 0, 4'b0110, 32'h1234_5678, 32'h1234_5678, 32'd0, 1, 0);
        go_check("add_ovf", 0, 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1);
        go_check("sub_ovf", 0, 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1);
        go_check("add_wrap", 0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        go_check("sub_neg_ovf", 0, 4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
        go_check("reset_mid", 1, 4'b0010, 32'd3, 32'd4, 32'd0, 1, 0);
        go_check("after_reset", 0, 4'b0010, 32'd3, 32'd4, 32'd7, 0, 0);
        go_check("hold", 0, 4'b0010, 32'd3, 32'd4, 32'd7, 0, 0);
        foreach (unused[i]) go_check($sformatf("unused_%b", unused[i]), 0, unused[i],
                                     32'hDEAD_BEEF, 32'h0F0F_1234, 32'd0, 1, 0);
        for (int k = 0; k < 600; k++) begin
            logic [3:0] c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : valid[$urandom_range(0, 5)];
            apply(($urandom_range(0, 31) == 0), c, pick(), pick());
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
